// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry sequencer.
package calc_pkg;

  localparam int BCD_W = 10;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, EXEC, SHOW} state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Hundreds digit is only 2 bits wide, so only tens and units can be out of range.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises an active-low push button and emits one pulse per debounced press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press     <= 1'b0;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
      press     <= 1'b0;
      // cnt_reg counts consecutive samples that disagree with the accepted level
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
        press     <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_entry_sequencer.sv
// Operand entry, ALU launch/capture and display control for the calculator.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ALU_TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] sw_val,
  input  logic             sw_neg,
  input  logic [1:0]       sw_op,
  input  logic             btn_enter_n,
  input  logic             btn_clear_n,
  input  logic             alu_done,
  input  logic [BCD_W-1:0] alu_result,
  input  logic             alu_neg,
  input  logic             alu_overflow,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [BCD_W-1:0] opa,
  output logic             opa_neg,
  output logic [BCD_W-1:0] opb,
  output logic             opb_neg,
  output logic [BCD_W-1:0] res,
  output logic             res_neg,
  output logic             res_ovf,
  output logic             show_result,
  output logic             entry_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       btn_n_vec;
  logic [1:0]       press_vec;
  logic             enter_press;
  logic             clear_press;

  assign btn_n_vec   = {btn_clear_n, btn_enter_n};
  assign enter_press = press_vec[0];
  assign clear_press = press_vec[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ENTER_A;
      cnt_reg     <= '0;
      alu_start   <= 1'b0;
      alu_op      <= OP_ADD;
      opa         <= '0;
      opa_neg     <= 1'b0;
      opb         <= '0;
      opb_neg     <= 1'b0;
      res         <= '0;
      res_neg     <= 1'b0;
      res_ovf     <= 1'b0;
      show_result <= 1'b0;
      entry_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      entry_err <= 1'b0;
      if (clear_press) begin
        state_reg   <= ENTER_A;
        cnt_reg     <= '0;
        alu_op      <= OP_ADD;
        opa         <= '0;
        opa_neg     <= 1'b0;
        opb         <= '0;
        opb_neg     <= 1'b0;
        res         <= '0;
        res_neg     <= 1'b0;
        res_ovf     <= 1'b0;
        show_result <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state_reg)
          ENTER_A: if (enter_press) begin
            if (bcd_valid(sw_val)) begin
              opa       <= sw_val;
              opa_neg   <= sw_neg && (sw_val != '0);
              state_reg <= ENTER_B;
            end else begin
              entry_err <= 1'b1;
            end
          end
          ENTER_B: if (enter_press) begin
            if (bcd_valid(sw_val)) begin
              opb       <= sw_val;
              opb_neg   <= sw_neg && (sw_val != '0);
              alu_op    <= sw_op;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= EXEC;
            end else begin
              entry_err <= 1'b1;
            end
          end
          EXEC: begin
            // A done arriving on the last allowed cycle still beats the timeout.
            if (alu_done) begin
              res         <= alu_result;
              res_neg     <= alu_neg && (alu_result != '0);
              res_ovf     <= alu_overflow;
              show_result <= 1'b1;
              busy        <= 1'b0;
              cnt_reg     <= '0;
              state_reg   <= SHOW;
            end else if (cnt_reg == CNT_W'(ALU_TIMEOUT - 1)) begin
              res         <= '0;
              res_neg     <= 1'b0;
              res_ovf     <= 1'b1;
              show_result <= 1'b1;
              busy        <= 1'b0;
              cnt_reg     <= '0;
              state_reg   <= SHOW;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          SHOW: if (enter_press) begin
            res         <= '0;
            res_neg     <= 1'b0;
            res_ovf     <= 1'b0;
            show_result <= 1'b0;
            state_reg   <= ENTER_A;
          end
          default: state_reg <= ENTER_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Randomised and directed bench for calc_entry_sequencer against a behavioural model.
module tb_calc_entry_sequencer;

  localparam int DEB = 4;
  localparam int TMO = 16;
  localparam int ST_A = 0, ST_B = 1, ST_EXEC = 2, ST_SHOW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] sw_val = '0;
  logic sw_neg = 1'b0;
  logic [1:0] sw_op = '0;
  logic btn_enter_n = 1'b1;
  logic btn_clear_n = 1'b1;
  logic alu_done = 1'b0;
  logic [9:0] alu_result = '0;
  logic alu_neg = 1'b0;
  logic alu_overflow = 1'b0;
  logic alu_start, opa_neg, opb_neg, res_neg, res_ovf, show_result, entry_err, busy;
  logic [1:0] alu_op;
  logic [9:0] opa, opb, res;

  calc_entry_sequencer #(.DEBOUNCE_CYCLES(DEB), .ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .sw_val(sw_val), .sw_neg(sw_neg), .sw_op(sw_op),
    .btn_enter_n(btn_enter_n), .btn_clear_n(btn_clear_n),
    .alu_done(alu_done), .alu_result(alu_result), .alu_neg(alu_neg), .alu_overflow(alu_overflow),
    .alu_start(alu_start), .alu_op(alu_op), .opa(opa), .opa_neg(opa_neg), .opb(opb),
    .opb_neg(opb_neg), .res(res), .res_neg(res_neg), .res_ovf(res_ovf),
    .show_result(show_result), .entry_err(entry_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  // ---------------- behavioural model ----------------
  int m_st = ST_A;
  int m_age = 0;
  logic [9:0] m_opa = '0, m_opb = '0, m_res = '0;
  logic m_opa_neg = 0, m_opb_neg = 0, m_res_neg = 0, m_ovf = 0, m_start = 0, m_err = 0;
  logic [1:0] m_op = '0;
  logic [DEB:0] h_e = '1, h_c = '1;
  logic m_lvl_e = 1, m_lvl_c = 1, m_press_e = 0, m_press_c = 0;

  logic [39:0] dut_vec, exp_vec;
  assign dut_vec = {alu_start, alu_op, opa, opa_neg, opb, opb_neg, res, res_neg, res_ovf,
                    show_result, entry_err, busy};
  assign exp_vec = {m_start, m_op, m_opa, m_opa_neg, m_opb, m_opb_neg, m_res, m_res_neg, m_ovf,
                    m_st == ST_SHOW, m_err, m_st == ST_EXEC};

  function automatic bit bcd_ok(input logic [9:0] v);
    int t = (int'(v) / 16) % 16;
    int u = int'(v) % 16;
    return (t <= 9) && (u <= 9);
  endfunction

  // A button's accepted level flips once DEB consecutive synchronised samples disagree with it.
  function automatic bit settled_flip(input logic [DEB:0] h, input logic lvl);
    for (int i = 1; i <= DEB; i++) if (h[i] == lvl) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_st = ST_A; m_age = 0; m_opa = '0; m_opb = '0; m_res = '0; m_op = '0;
    m_opa_neg = 0; m_opb_neg = 0; m_res_neg = 0; m_ovf = 0; m_start = 0; m_err = 0;
    h_e = '1; h_c = '1; m_lvl_e = 1; m_lvl_c = 1; m_press_e = 0; m_press_c = 0;
  endtask

  task automatic model_step();
    m_start = 0;
    m_err = 0;
    if (m_press_c) begin
      m_st = ST_A; m_age = 0; m_opa = '0; m_opb = '0; m_res = '0; m_op = '0;
      m_opa_neg = 0; m_opb_neg = 0; m_res_neg = 0; m_ovf = 0;
    end else if (m_st == ST_A && m_press_e) begin
      if (bcd_ok(sw_val)) begin
        m_opa = sw_val; m_opa_neg = sw_neg && (sw_val != 0); m_st = ST_B;
      end else m_err = 1;
    end else if (m_st == ST_B && m_press_e) begin
      if (bcd_ok(sw_val)) begin
        m_opb = sw_val; m_opb_neg = sw_neg && (sw_val != 0); m_op = sw_op;
        m_st = ST_EXEC; m_start = 1; m_age = 0;
      end else m_err = 1;
    end else if (m_st == ST_EXEC) begin
      m_age = m_age + 1;
      if (alu_done) begin
        m_res = alu_result; m_res_neg = alu_neg && (alu_result != 0); m_ovf = alu_overflow;
        m_st = ST_SHOW;
      end else if (m_age == TMO) begin
        m_res = '0; m_res_neg = 0; m_ovf = 1; m_st = ST_SHOW;
      end
    end else if (m_st == ST_SHOW && m_press_e) begin
      m_res = '0; m_res_neg = 0; m_ovf = 0; m_st = ST_A;
    end
    m_press_e = 0;
    if (settled_flip(h_e, m_lvl_e)) begin m_lvl_e = ~m_lvl_e; m_press_e = ~m_lvl_e; end
    m_press_c = 0;
    if (settled_flip(h_c, m_lvl_c)) begin m_lvl_c = ~m_lvl_c; m_press_c = ~m_lvl_c; end
    h_e = {h_e[DEB-1:0], btn_enter_n};
    h_c = {h_c[DEB-1:0], btn_clear_n};
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) chk("outputs_in_reset", dut_vec, 40'h0);
      else begin
        chk("outputs_vs_model", dut_vec, exp_vec);
        if (alu_start === 1'b1) start_cnt++;
        if (entry_err === 1'b1) err_cnt++;
      end
    end
  end

  task automatic press(input bit clr, input bit ent, input int hold);
    @(negedge clk);
    if (ent) btn_enter_n = 1'b0;
    if (clr) btn_clear_n = 1'b0;
    repeat (hold) @(negedge clk);
    btn_enter_n = 1'b1;
    btn_clear_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (alu_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_tests++;
    if (alu_start !== 1'b1) begin n_fail++; $display("FAIL %s: alu_start not seen within 40 cycles", name); end
  endtask

  int s0, e0, bc;
  int e_left, c_left, mode_left;
  bit done_en;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_all_zero", dut_vec, 40'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // invalid A, then a short bounce that must be ignored
    sw_val = 10'h03A; sw_neg = 1'b0; e0 = err_cnt;
    press(0, 1, 6);
    chk("invalid_a_err_pulses", 40'(err_cnt - e0), 40'd1);
    chk("invalid_a_opa_kept", 40'(opa), 40'h0);
    sw_val = 10'h125; sw_neg = 1'b1;
    press(0, 1, 2);
    chk("bounce_no_latch", 40'(opa), 40'h0);

    // valid A with a long hold: one press only
    press(0, 1, 50);
    chk("opa_latched", 40'(opa), 40'h125);
    chk("opa_neg_latched", 40'(opa_neg), 40'd1);
    chk("model_opa", 40'(m_opa), 40'h125);
    chk("held_no_second_press", 40'(busy), 40'd0);

    // B entry and ALU completion after 5 cycles
    sw_val = 10'h042; sw_neg = 1'b1; sw_op = 2'd1; s0 = start_cnt;
    @(negedge clk); btn_enter_n = 1'b0;
    wait_start("b_entry_start");
    chk("alu_op_latched", 40'(alu_op), 40'd1);
    chk("busy_in_exec", 40'(busy), 40'd1);
    btn_enter_n = 1'b1;
    @(negedge clk);
    chk("alu_start_one_cycle", 40'(alu_start), 40'd0);
    repeat (4) @(negedge clk);
    alu_done = 1'b1; alu_result = 10'h083; alu_neg = 1'b0; alu_overflow = 1'b0;
    @(negedge clk);
    alu_done = 1'b0;
    chk("res_latched", 40'(res), 40'h083);
    chk("show_after_done", 40'(show_result), 40'd1);
    chk("ovf_after_done", 40'(res_ovf), 40'd0);
    chk("opb_neg_latched", 40'(opb_neg), 40'd1);
    chk("single_start", 40'(start_cnt - s0), 40'd1);
    repeat (8) @(negedge clk);

    // timeout path
    press(0, 1, 6);
    sw_val = 10'h007; sw_neg = 1'b0; press(0, 1, 6);
    sw_val = 10'h010; sw_op = 2'd0;
    @(negedge clk); btn_enter_n = 1'b0;
    wait_start("timeout_start");
    btn_enter_n = 1'b1;
    bc = 1;
    for (int i = 0; i < 40 && show_result !== 1'b1; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bc++;
    end
    chk("exec_cycles_before_timeout", 40'(bc), 40'd16);
    chk("timeout_ovf", 40'(res_ovf), 40'd1);
    chk("timeout_res", 40'(res), 40'h0);
    chk("timeout_show", 40'(show_result), 40'd1);
    repeat (8) @(negedge clk);
    press(0, 1, 6);
    chk("show_exit_ovf_clear", 40'(res_ovf), 40'd0);
    chk("show_exit_display", 40'(show_result), 40'd0);
    chk("opa_retained", 40'(opa), 40'h007);
    chk("opb_retained", 40'(opb), 40'h010);

    // no negative zero
    sw_val = 10'h000; sw_neg = 1'b1; press(0, 1, 6);
    chk("zero_opa_not_neg", 40'(opa_neg), 40'd0);
    sw_val = 10'h001; sw_op = 2'd2;
    @(negedge clk); btn_enter_n = 1'b0;
    wait_start("zero_start");
    btn_enter_n = 1'b1;
    alu_done = 1'b1; alu_result = 10'h000; alu_neg = 1'b1; alu_overflow = 1'b0;
    @(negedge clk);
    alu_done = 1'b0; alu_neg = 1'b0;
    chk("zero_res_not_neg", 40'(res_neg), 40'd0);
    chk("zero_show", 40'(show_result), 40'd1);
    repeat (8) @(negedge clk);
    press(0, 1, 6);

    // clear and enter together in ENTER_B
    sw_val = 10'h200; sw_neg = 1'b0; press(0, 1, 6);
    sw_val = 10'h300; s0 = start_cnt;
    press(1, 1, 6);
    chk("clear_opa_zero", 40'(opa), 40'h0);
    chk("clear_busy", 40'(busy), 40'd0);
    chk("clear_no_start", 40'(start_cnt - s0), 40'd0);
    sw_val = 10'h111; press(0, 1, 6);
    chk("after_clear_in_enter_a", 40'(opa), 40'h111);

    // reset mid-EXEC
    sw_val = 10'h222;
    @(negedge clk); btn_enter_n = 1'b0;
    wait_start("reset_test_start");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_zero", dut_vec, 40'h0);
    btn_enter_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; s0 = start_cnt;
    repeat (40) @(negedge clk);
    chk("no_start_after_reset", 40'(start_cnt - s0), 40'd0);

    // randomised phase
    e_left = 0; c_left = 100; mode_left = 0; done_en = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (e_left == 0) begin
        btn_enter_n = ~btn_enter_n;
        e_left = btn_enter_n ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 10));
      end else e_left--;
      if (c_left == 0) begin
        btn_clear_n = ~btn_clear_n;
        c_left = btn_clear_n ? int'($urandom_range(30, 300)) : int'($urandom_range(1, 8));
      end else c_left--;
      if ($urandom_range(0, 7) == 0) sw_val = '0;
      else if ($urandom_range(0, 1) == 0)
        sw_val = {2'($urandom), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else sw_val = 10'($urandom);
      sw_neg = 1'($urandom);
      sw_op = 2'($urandom);
      if (mode_left == 0) begin
        done_en = ($urandom_range(0, 3) != 0);
        mode_left = int'($urandom_range(20, 80));
      end else mode_left--;
      alu_done = done_en && ($urandom_range(0, 5) == 0);
      alu_result = ($urandom_range(0, 5) == 0) ? 10'h000 : 10'($urandom);
      alu_neg = 1'($urandom);
      alu_overflow = 1'($urandom);
    end
    btn_enter_n = 1'b1; btn_clear_n = 1'b1; alu_done = 1'b0;
    repeat (10) @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
